// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback controller.
package rf_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_rec_t;

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// Writeback sources, issue port and register-file write port of rf_writeback_ctrl.
interface rf_writeback_ctrl_if;
    import rf_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] C;
    logic [ADDR_W-1:0] Caddr;
    logic              Load;
    logic [NREGS-1:0]  pending;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output issue_valid, issue_addr,
        input  alu_ready, mem_ready, C, Caddr, Load, pending
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  issue_valid, issue_addr,
        output alu_ready, mem_ready, C, Caddr, Load, pending
    );

endinterface

// File: rtl/wb_slot.sv
// One-entry writeback buffer: fills on valid&&ready, empties when granted.
module wb_slot
    import rf_pkg::*;
(
    input  logic    Clk,
    input  logic    Clear_n,
    input  logic    in_valid,
    output logic    in_ready,
    input  wr_rec_t in_rec,
    input  logic    grant,
    output logic    full,
    output logic    fill,
    output wr_rec_t rec
);

    // Ready depends only on full, so accept and drain never share an edge.
    assign in_ready = !full;
    assign fill     = in_valid && !full;

    // NOTE: non-blocking assignments in clocked blocks, so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            full <= 1'b0;
            // NOTE: the payload is reset along with the flag so no X can ever
            // reach the write port through a grant.
            rec  <= '0;
        end else if (fill) begin
            full <= 1'b1;
            rec  <= in_rec;
        end else if (grant) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Arbitrates ALU and load results onto the single register-file write port
// and tracks outstanding writes for hazard stalls.
module rf_writeback_ctrl
    import rf_pkg::*;
(
    input  logic                Clk,
    input  logic                Clear_n,
    rf_writeback_ctrl_if.slave  bus
);

    wr_rec_t alu_in, mem_in, alu_rec, mem_rec, grant_rec;
    logic    alu_full, mem_full, alu_fill, mem_fill;
    logic    alu_grant, mem_grant, grant_valid;
    logic    alu_ready, mem_ready;
    src_e    grant_src;
    logic    mem_older;

    logic [DATA_W-1:0] c_q;
    logic [ADDR_W-1:0] caddr_q;
    logic              load_q;
    logic [NREGS-1:0]  pending_q, pending_d;

    assign alu_in = '{addr: bus.alu_addr, data: bus.alu_data};
    assign mem_in = '{addr: bus.mem_addr, data: bus.mem_data};

    wb_slot u_alu_slot (
        .Clk      (Clk),
        .Clear_n  (Clear_n),
        .in_valid (bus.alu_valid),
        .in_ready (alu_ready),
        .in_rec   (alu_in),
        .grant    (alu_grant),
        .full     (alu_full),
        .fill     (alu_fill),
        .rec      (alu_rec)
    );

    wb_slot u_mem_slot (
        .Clk      (Clk),
        .Clear_n  (Clear_n),
        .in_valid (bus.mem_valid),
        .in_ready (mem_ready),
        .in_rec   (mem_in),
        .grant    (mem_grant),
        .full     (mem_full),
        .fill     (mem_fill),
        .rec      (mem_rec)
    );

    // Oldest full slot wins; address equality plays no part, so same-register
    // writes retire in acceptance order.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can infer a latch.
        grant_valid = alu_full || mem_full;
        grant_src   = SRC_ALU;
        if (mem_full && (!alu_full || mem_older))
            grant_src = SRC_MEM;
        grant_rec   = (grant_src == SRC_MEM) ? mem_rec : alu_rec;
    end

    assign alu_grant = grant_valid && (grant_src == SRC_ALU);
    assign mem_grant = grant_valid && (grant_src == SRC_MEM);

    // mem_older only matters while both slots are full; a resident slot that
    // survives this edge is older than one filling on it.
    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n)
            mem_older <= 1'b0;
        else if (alu_fill && mem_fill)
            mem_older <= 1'b1;
        else if (alu_fill)
            mem_older <= mem_full && !mem_grant;
        else if (mem_fill)
            mem_older <= !(alu_full && !alu_grant);
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            load_q  <= 1'b0;
            c_q     <= '0;
            caddr_q <= '0;
        end else begin
            load_q <= grant_valid;
            if (grant_valid) begin
                c_q     <= grant_rec.data;
                caddr_q <= grant_rec.addr;
            end
        end
    end

    // Clear before set: a newly issued writer to the retiring register stays pending.
    always_comb begin
        pending_d = pending_q;
        if (grant_valid)
            pending_d[grant_rec.addr] = 1'b0;
        if (bus.issue_valid)
            pending_d[bus.issue_addr] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

    assign bus.alu_ready = alu_ready;
    assign bus.mem_ready = mem_ready;
    assign bus.C         = c_q;
    assign bus.Caddr     = caddr_q;
    assign bus.Load      = load_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl; a write log records every
// register-file write captured at the clock edge.
module tb_rf_writeback_ctrl;
    import rf_pkg::*;

    logic Clk = 1'b0;
    logic Clear_n = 1'b1;
    always #5 Clk = ~Clk;

    rf_writeback_ctrl_if bus ();

    rf_writeback_ctrl dut (
        .Clk     (Clk),
        .Clear_n (Clear_n),
        .bus     (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Register-file side: every edge with Load high is one write.
    wr_rec_t wlog[$];
    always @(posedge Clk)
        if (bus.Load === 1'b1)
            wlog.push_back('{addr: bus.Caddr, data: bus.C});

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
        bus.issue_valid = 1'b0; bus.issue_addr = '0;
    endtask

    task automatic drive_alu(input logic [3:0] a, input logic [15:0] d);
        bus.alu_valid = 1'b1; bus.alu_addr = a; bus.alu_data = d;
    endtask

    task automatic drive_mem(input logic [3:0] a, input logic [15:0] d);
        bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_data = d;
    endtask

    task automatic test_reset();
        int base;
        idle();
        #1 Clear_n = 1'b0;
        drive_alu(4'd2, 16'h0202);
        drive_mem(4'd1, 16'h0101);
        tick(3);
        tests_run++; if (bus.Load !== 1'b0) begin tests_failed++; $display("FAIL reset_load: got %b want 0", bus.Load); end
        tests_run++; if (bus.C !== 16'h0000) begin tests_failed++; $display("FAIL reset_c: got %h want 0000", bus.C); end
        tests_run++; if (bus.Caddr !== 4'h0) begin tests_failed++; $display("FAIL reset_caddr: got %h want 0", bus.Caddr); end
        tests_run++; if (bus.pending !== 16'h0000) begin tests_failed++; $display("FAIL reset_pending: got %h want 0000", bus.pending); end
        tests_run++; if ({bus.alu_ready, bus.mem_ready} !== 2'b11) begin tests_failed++; $display("FAIL reset_ready: got %b want 11", {bus.alu_ready, bus.mem_ready}); end
        base = wlog.size();
        Clear_n = 1'b1;
        tick();                                   // edge t: both accepted
        idle();
        tests_run++; if ({bus.Load, bus.alu_ready, bus.mem_ready} !== 3'b000) begin tests_failed++; $display("FAIL first_accept: load/ready got %b want 000", {bus.Load, bus.alu_ready, bus.mem_ready}); end
        tick();                                   // edge t+1: mem granted (older on a tie)
        tests_run++; if ({bus.Load, bus.Caddr, bus.C} !== {1'b1, 4'd1, 16'h0101}) begin tests_failed++; $display("FAIL first_write: got %b/%h/%h want 1/1/0101", bus.Load, bus.Caddr, bus.C); end
        tick();
        tests_run++; if ({bus.Load, bus.Caddr, bus.C} !== {1'b1, 4'd2, 16'h0202}) begin tests_failed++; $display("FAIL second_write: got %b/%h/%h want 1/2/0202", bus.Load, bus.Caddr, bus.C); end
        tick();
        tests_run++; if (wlog.size() - base !== 2 || bus.Load !== 1'b0) begin tests_failed++; $display("FAIL reset_drain: writes got %0d want 2, load %b", wlog.size() - base, bus.Load); end
    endtask

    task automatic test_single_alu();
        int base = wlog.size();
        drive_alu(4'd5, 16'hBEEF);
        tick();                                   // edge t
        idle();
        tests_run++; if ({bus.alu_ready, bus.Load} !== 2'b00) begin tests_failed++; $display("FAIL alu_accept: ready/load got %b want 00", {bus.alu_ready, bus.Load}); end
        tick();                                   // edge t+1
        tests_run++; if ({bus.Load, bus.Caddr, bus.C} !== {1'b1, 4'd5, 16'hBEEF}) begin tests_failed++; $display("FAIL alu_write: got %b/%h/%h want 1/5/beef", bus.Load, bus.Caddr, bus.C); end
        tests_run++; if (bus.alu_ready !== 1'b1) begin tests_failed++; $display("FAIL alu_ready_back: got %b want 1", bus.alu_ready); end
        tick();                                   // edge t+2: register file captures
        tests_run++; if (wlog.size() - base !== 1 || wlog[base] !== wr_rec_t'{addr: 4'd5, data: 16'hBEEF}) begin tests_failed++; $display("FAIL alu_capture: writes %0d, first %h want 1 write 5beef", wlog.size() - base, (wlog.size() > base) ? wlog[base] : '0); end
        tests_run++; if (bus.Load !== 1'b0) begin tests_failed++; $display("FAIL alu_load_drop: got %b want 0", bus.Load); end
    endtask

    task automatic test_same_addr();
        int base = wlog.size();
        drive_mem(4'd3, 16'h1111);
        drive_alu(4'd3, 16'h2222);
        tick();
        idle();
        tick(3);
        tests_run++; if (wlog.size() - base !== 2) begin tests_failed++; $display("FAIL same_addr_count: got %0d want 2", wlog.size() - base); end
        else begin
            tests_run++; if (wlog[base] !== wr_rec_t'{addr: 4'd3, data: 16'h1111}) begin tests_failed++; $display("FAIL same_addr_first: got %h want 31111", wlog[base]); end
            tests_run++; if (wlog[base+1] !== wr_rec_t'{addr: 4'd3, data: 16'h2222}) begin tests_failed++; $display("FAIL same_addr_last: got %h want 32222", wlog[base+1]); end
        end
    endtask

    task automatic test_age_order();
        int base = wlog.size();
        wr_rec_t exp_q[4];
        exp_q[0] = '{addr: 4'd12, data: 16'h0C0C};
        exp_q[1] = '{addr: 4'd10, data: 16'h0A0A};
        exp_q[2] = '{addr: 4'd7,  data: 16'hAAAA};
        exp_q[3] = '{addr: 4'd9,  data: 16'h5555};
        drive_alu(4'd10, 16'h0A0A);
        drive_mem(4'd12, 16'h0C0C);
        tick();                                   // t0: both accepted
        bus.alu_valid = 1'b0;
        drive_mem(4'd7, 16'hAAAA);                // held off: mem slot busy
        tick();                                   // t1: mem granted
        drive_alu(4'd9, 16'h5555);                // held off until alu drains
        tick();                                   // t2: mem accepts 7
        tests_run++; if ({bus.mem_ready, bus.alu_ready} !== 2'b01) begin tests_failed++; $display("FAIL age_ready: mem/alu got %b want 01", {bus.mem_ready, bus.alu_ready}); end
        bus.mem_valid = 1'b0;
        tick();                                   // t3: alu accepts 9
        idle();
        tick(3);
        tests_run++; if (wlog.size() - base !== 4) begin tests_failed++; $display("FAIL age_count: got %0d want 4", wlog.size() - base); end
        else
            for (int i = 0; i < 4; i++) begin
                tests_run++; if (wlog[base+i] !== exp_q[i]) begin tests_failed++; $display("FAIL age_order[%0d]: got %h want %h", i, wlog[base+i], exp_q[i]); end
            end
    endtask

    task automatic test_addr0();
        drive_mem(4'd0, 16'hFFFF);
        tick();
        idle();
        tick();
        tests_run++; if ({bus.Load, bus.Caddr, bus.C} !== {1'b1, 4'd0, 16'hFFFF}) begin tests_failed++; $display("FAIL addr0_write: got %b/%h/%h want 1/0/ffff", bus.Load, bus.Caddr, bus.C); end
        tick();
    endtask

    task automatic test_scoreboard();
        bus.issue_valid = 1'b1; bus.issue_addr = 4'd4;
        tick();
        idle();
        tests_run++; if (bus.pending !== 16'h0010) begin tests_failed++; $display("FAIL sb_set: got %h want 0010", bus.pending); end
        drive_alu(4'd4, 16'h4444);
        tick();                                   // accept
        idle();
        tests_run++; if (bus.pending !== 16'h0010) begin tests_failed++; $display("FAIL sb_hold: got %h want 0010", bus.pending); end
        tick();                                   // grant clears
        tests_run++; if (bus.pending !== 16'h0000) begin tests_failed++; $display("FAIL sb_clear: got %h want 0000", bus.pending); end
        bus.issue_valid = 1'b1; bus.issue_addr = 4'd4;
        tick();
        drive_alu(4'd4, 16'h4545);
        bus.issue_valid = 1'b0;
        tick();                                   // accept
        idle();
        bus.issue_valid = 1'b1; bus.issue_addr = 4'd4;
        tick();                                   // grant and issue on the same edge
        idle();
        tests_run++; if (bus.pending !== 16'h0010) begin tests_failed++; $display("FAIL sb_set_wins: got %h want 0010", bus.pending); end
        drive_alu(4'd4, 16'h4646);
        tick();
        idle();
        tick();
        tests_run++; if (bus.pending !== 16'h0000) begin tests_failed++; $display("FAIL sb_final_clear: got %h want 0000", bus.pending); end
        tick();
    endtask

    task automatic test_mid_reset();
        int base;
        drive_alu(4'd8, 16'h8888);
        drive_mem(4'd11, 16'hBBBB);
        bus.issue_valid = 1'b1; bus.issue_addr = 4'd8;
        tick();                                   // t0: both slots full, pending[8]
        idle();
        base = wlog.size();
        tick();                                   // t1: mem granted, alu still full
        tests_run++; if ({bus.Load, bus.pending[8], bus.alu_ready} !== 3'b110) begin tests_failed++; $display("FAIL mid_pre: load/pend8/alu_ready got %b want 110", {bus.Load, bus.pending[8], bus.alu_ready}); end
        #2 Clear_n = 1'b0;
        #1;
        tests_run++; if ({bus.Load, bus.C, bus.Caddr} !== {1'b0, 16'h0000, 4'h0}) begin tests_failed++; $display("FAIL mid_async: load/c/caddr got %b/%h/%h want 0/0000/0", bus.Load, bus.C, bus.Caddr); end
        tests_run++; if ({bus.pending, bus.alu_ready, bus.mem_ready} !== {16'h0000, 2'b11}) begin tests_failed++; $display("FAIL mid_clear: pending %h ready %b want 0000/11", bus.pending, {bus.alu_ready, bus.mem_ready}); end
        #2 Clear_n = 1'b1;
        tick(3);
        tests_run++; if (wlog.size() - base !== 0 || bus.Load !== 1'b0) begin tests_failed++; $display("FAIL mid_no_write: writes got %0d want 0, load %b", wlog.size() - base, bus.Load); end
    endtask

    initial begin
        idle();
        test_reset();
        test_single_alu();
        test_same_addr();
        test_age_order();
        test_addr0();
        test_scoreboard();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
